// File: rtl/myproject_sdiv_26s_16s_11_seq.sv
// Sequential signed restoring divider: 26-bit signed dividend / 16-bit signed divisor,
// one quotient bit per cycle, saturating 11-bit signed quotient, dividend-signed remainder.
module myproject_sdiv_26s_16s_11_seq #(
    parameter int unsigned DIVIDEND_W = 26,
    parameter int unsigned DIVISOR_W  = 16,
    parameter int unsigned QUOT_W     = 11
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [QUOT_W-1:0]     quot,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  ovf,
    output logic                  div0
);

    localparam int unsigned CNT_W  = $clog2(DIVIDEND_W);
    localparam int unsigned PART_W = DIVISOR_W + 1;

    localparam logic [DIVIDEND_W-1:0] QMAX_MAG = DIVIDEND_W'((2 ** (QUOT_W - 1)) - 1);
    localparam logic [DIVIDEND_W-1:0] QMIN_MAG = DIVIDEND_W'(2 ** (QUOT_W - 1));
    localparam logic [QUOT_W-1:0]     QPOS_SAT = {1'b0, {(QUOT_W - 1){1'b1}}};
    localparam logic [QUOT_W-1:0]     QNEG_SAT = {1'b1, {(QUOT_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q,   state_d;
    logic                    in_rdy_q,  in_rdy_d;
    logic                    out_vld_q, out_vld_d;
    logic [DIVIDEND_W-1:0]   dvd_q,     dvd_d;
    logic [DIVISOR_W-1:0]    dvs_q,     dvs_d;
    logic [PART_W-1:0]       part_q,    part_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic                    sgn_dvd_q, sgn_dvd_d;
    logic                    sgn_dvs_q, sgn_dvs_d;
    logic [QUOT_W-1:0]       quot_q,    quot_d;
    logic [DIVISOR_W-1:0]    rem_q,     rem_d;
    logic                    ovf_q,     ovf_d;
    logic                    div0_q,    div0_d;

    logic [PART_W-1:0]       part_sh;
    logic [PART_W-1:0]       part_sub;
    logic                    q_neg;

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= IDLE;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            part_q    <= '0;
            cnt_q     <= '0;
            sgn_dvd_q <= 1'b0;
            sgn_dvs_q <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            part_q    <= part_d;
            cnt_q     <= cnt_d;
            sgn_dvd_q <= sgn_dvd_d;
            sgn_dvs_q <= sgn_dvs_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            ovf_q     <= ovf_d;
            div0_q    <= div0_d;
        end
    end

    // Next-state, restoring-division step and result formatting.
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        part_d    = part_q;
        cnt_d     = cnt_q;
        sgn_dvd_d = sgn_dvd_q;
        sgn_dvs_d = sgn_dvs_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        ovf_d     = ovf_q;
        div0_d    = div0_q;

        // Stored partial is always below |divisor|, so its top bit is zero before the shift.
        part_sh  = PART_W'({part_q, dvd_q[DIVIDEND_W-1]});
        part_sub = part_sh - {1'b0, dvs_q};
        q_neg    = sgn_dvd_q ^ sgn_dvs_q;

        case (state_q)
            IDLE: begin
                if (in_vld && in_rdy_q) begin
                    dvd_d     = dividend[DIVIDEND_W-1] ? (~dividend + DIVIDEND_W'(1)) : dividend;
                    dvs_d     = divisor[DIVISOR_W-1] ? (~divisor + DIVISOR_W'(1)) : divisor;
                    sgn_dvd_d = dividend[DIVIDEND_W-1];
                    sgn_dvs_d = divisor[DIVISOR_W-1];
                    part_d    = '0;
                    cnt_d     = '0;
                    state_d   = (divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                // Dividend register shifts out numerator bits and shifts in quotient bits.
                if (part_sh >= {1'b0, dvs_q}) begin
                    part_d = part_sub;
                    dvd_d  = {dvd_q[DIVIDEND_W-2:0], 1'b1};
                end else begin
                    part_d = part_sh;
                    dvd_d  = {dvd_q[DIVIDEND_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                if (dvs_q == '0) begin
                    div0_d = 1'b1;
                    ovf_d  = 1'b0;
                    rem_d  = '0;
                    quot_d = sgn_dvd_q ? QNEG_SAT : QPOS_SAT;
                end else begin
                    div0_d = 1'b0;
                    rem_d  = sgn_dvd_q ? (~part_q[DIVISOR_W-1:0] + DIVISOR_W'(1))
                                       : part_q[DIVISOR_W-1:0];
                    if (!q_neg) begin
                        ovf_d  = (dvd_q > QMAX_MAG);
                        quot_d = (dvd_q > QMAX_MAG) ? QPOS_SAT : dvd_q[QUOT_W-1:0];
                    end else begin
                        ovf_d  = (dvd_q > QMIN_MAG);
                        quot_d = (dvd_q > QMIN_MAG) ? QNEG_SAT
                                                    : (~dvd_q[QUOT_W-1:0] + QUOT_W'(1));
                    end
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_rdy_d  = (state_d == IDLE);
        out_vld_d = (state_d == DONE);
    end

    assign in_rdy  = in_rdy_q;
    assign out_vld = out_vld_q;
    assign quot    = quot_q;
    assign rem     = rem_q;
    assign ovf     = ovf_q;
    assign div0    = div0_q;

endmodule
